// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
//   - SN/WN/WT/ST : 2-bit saturating counter states
//   - IDX_W_DEFAULT : default table index width (16 entries)
//   - sat_update() : next counter state for a resolved outcome
package branch_predictor_pkg;

    localparam logic [1:0] SN = 2'b00;  // strong not-taken
    localparam logic [1:0] WN = 2'b01;  // weak not-taken
    localparam logic [1:0] WT = 2'b10;  // weak taken
    localparam logic [1:0] ST = 2'b11;  // strong taken

    localparam int unsigned IDX_W_DEFAULT = 4;

    // Taken moves towards ST, not-taken towards SN; both endpoints self-loop.
    function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (state == ST) ? ST : state + 2'd1;
        end else begin
            nxt = (state == SN) ? SN : state - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF/ID-side signal bundle between the pipeline and the branch predictor.
//   master : pipeline side (drives PC, pre-decode, resolution, stall/flush)
//   slave  : predictor side (drives BrPre_if_o and BrPre_o)
interface branch_predictor_if;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] if_pc_i;
    logic        if_is_branch_i;
    logic        BrPre_if_o;
    logic        BrPre_o;
    logic        Brncheq_i;
    logic        Brnchne_i;
    logic        Branch_i;
    logic        missPre_i;

    modport master (
        output stall_i, flush_i, if_pc_i, if_is_branch_i,
        output Brncheq_i, Brnchne_i, Branch_i, missPre_i,
        input  BrPre_if_o, BrPre_o
    );

    modport slave (
        input  stall_i, flush_i, if_pc_i, if_is_branch_i,
        input  Brncheq_i, Brnchne_i, Branch_i, missPre_i,
        output BrPre_if_o, BrPre_o
    );
endinterface

// File: rtl/branch_predictor_counter.sv
// brpred_counter: one 2-bit saturating prediction counter.
//   clk, rst_n : clock, asynchronous active-low reset (to INIT_STATE)
//   en_i       : apply one training step this edge
//   taken_i    : resolved direction for the training step
//   state_o    : current counter state
module brpred_counter
    import branch_predictor_pkg::*;
#(
    parameter logic [1:0] INIT_STATE = WN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       taken_i,
    output logic [1:0] state_o
);

    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = sat_update(state_q, taken_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: PC-indexed table of 2-bit saturating counters.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : IF lookup (if_pc_i, if_is_branch_i -> BrPre_if_o),
//                     ID-aligned prediction (BrPre_o), resolution/training
//                     (Brncheq_i, Brnchne_i, Branch_i, missPre_i), stall_i, flush_i
//   hit_cnt_o, miss_cnt_o : prediction statistics, only when BRPRED_STATS_EN is defined
// Optional feature macro: BRPRED_STATS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W      = IDX_W_DEFAULT,
    parameter logic [1:0]  INIT_STATE = WN
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
`ifdef BRPRED_STATS_EN
    ,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
`endif
);

    localparam int unsigned NumEntries = 2 ** IDX_W;

    logic [IDX_W-1:0] if_idx;
    logic [1:0]       ctr_state [NumEntries];
    logic             upd;

    logic             id_pred_q, id_pred_d;
    logic             id_valid_q, id_valid_d;
    logic [IDX_W-1:0] id_idx_q, id_idx_d;

    // Word-aligned PC: bits [1:0] and the bits above the index never matter.
    assign if_idx = bus.if_pc_i[IDX_W+1:2];

    // No bypass: a same-cycle update becomes visible on the next lookup.
    assign bus.BrPre_if_o = bus.if_is_branch_i & ctr_state[if_idx][1];
    assign bus.BrPre_o    = id_pred_q;

    // Train only when the branch actually leaves ID; stalled cycles may still
    // carry unforwarded operands.
    assign upd = id_valid_q & (bus.Brncheq_i | bus.Brnchne_i) & ~bus.stall_i;

    for (genvar i = 0; i < NumEntries; i++) begin : g_ctr
        brpred_counter #(
            .INIT_STATE (INIT_STATE)
        ) u_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (upd && (id_idx_q == IDX_W'(i))),
            .taken_i (bus.Branch_i),
            .state_o (ctr_state[i])
        );
    end

    // Stall wins over flush.
    always_comb begin
        id_pred_d  = id_pred_q;
        id_valid_d = id_valid_q;
        id_idx_d   = id_idx_q;
        if (!bus.stall_i) begin
            if (bus.flush_i) begin
                id_pred_d  = 1'b0;
                id_valid_d = 1'b0;
                id_idx_d   = '0;
            end else begin
                id_pred_d  = bus.BrPre_if_o;
                id_valid_d = bus.if_is_branch_i;
                id_idx_d   = if_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pred_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_idx_q   <= '0;
        end else begin
            id_pred_q  <= id_pred_d;
            id_valid_q <= id_valid_d;
            id_idx_q   <= id_idx_d;
        end
    end

`ifdef BRPRED_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd) begin
            if (bus.missPre_i) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end else begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    logic unused_pc;
    assign unused_pc = ^{bus.if_pc_i[31:IDX_W+2], bus.if_pc_i[1:0]};
`else
    logic unused_pc;
    assign unused_pc = ^{bus.if_pc_i[31:IDX_W+2], bus.if_pc_i[1:0], bus.missPre_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int NUM   = 16;
    localparam int INIT  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if bus();

`ifdef BRPRED_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    branch_predictor #(
        .IDX_W      (IDX_W),
        .INIT_STATE (2'b01)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef BRPRED_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    // Reference model: counter strengths 0..3 per table slot, plus the branch
    // record currently sitting in ID.
    int          m_ctr [NUM];
    bit          m_valid;
    bit          m_pred;
    int          m_idx;
    int unsigned m_hit;
    int unsigned m_miss;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % NUM);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) m_ctr[i] = INIT;
        m_valid = 0;
        m_pred  = 0;
        m_idx   = 0;
        m_hit   = 0;
        m_miss  = 0;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One pipeline cycle: drive, check mid-cycle, clock, advance model.
    task automatic cycle(input string tag, input logic [31:0] pc, input bit br,
                         input bit beq, input bit bne, input bit taken, input bit miss,
                         input bit stall, input bit flush);
        bit exp_if;
        bit upd;
        bus.if_pc_i        = pc;
        bus.if_is_branch_i = br;
        bus.Brncheq_i      = beq;
        bus.Brnchne_i      = bne;
        bus.Branch_i       = taken;
        bus.missPre_i      = miss;
        bus.stall_i        = stall;
        bus.flush_i        = flush;
        #2;
        exp_if = br && (m_ctr[idx_of(pc)] >= 2);
        chk({tag, ".BrPre_if"}, bus.BrPre_if_o, exp_if);
        chk({tag, ".BrPre"}, bus.BrPre_o, m_pred);
`ifdef BRPRED_STATS_EN
        chk32({tag, ".hit"}, hit_cnt, m_hit);
        chk32({tag, ".miss"}, miss_cnt, m_miss);
`endif
        @(posedge clk);
        upd = m_valid && (beq || bne) && !stall;
        if (upd) begin
            if (taken) m_ctr[m_idx] = (m_ctr[m_idx] < 3) ? m_ctr[m_idx] + 1 : 3;
            else       m_ctr[m_idx] = (m_ctr[m_idx] > 0) ? m_ctr[m_idx] - 1 : 0;
            if (miss) m_miss++;
            else      m_hit++;
        end
        if (!stall) begin
            if (flush) begin
                m_valid = 0;
                m_pred  = 0;
                m_idx   = 0;
            end else begin
                m_valid = br;
                m_pred  = exp_if;
                m_idx   = idx_of(pc);
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        bit rbr, rbeq, rbne, rst_bit;
        int pick;

        model_reset();
        bus.if_pc_i        = 32'h40;
        bus.if_is_branch_i = 1'b1;
        bus.Brncheq_i      = 1'b0;
        bus.Brnchne_i      = 1'b0;
        bus.Branch_i       = 1'b0;
        bus.missPre_i      = 1'b0;
        bus.stall_i        = 1'b0;
        bus.flush_i        = 1'b0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.BrPre", bus.BrPre_o, 1'b0);
        chk("reset.BrPre_if", bus.BrPre_if_o, 1'b0);
        rst_n = 1'b1;
        #2;

        // Any PC after reset predicts not-taken.
        cycle("post_reset0", 32'h0000_1234, 1, 0, 0, 0, 0, 0, 0);
        cycle("post_reset1", 32'hdead_bee8, 1, 0, 0, 0, 0, 0, 0);
        cycle("idle", 32'h0, 0, 0, 0, 0, 0, 0, 0);

        // Train idx 0 towards taken: 01 -> 10 -> 11 -> 11.
        cycle("train_fetch", 32'h40, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("train_taken", 32'h40, 1, 1, 0, 1, 0, 0, 0);

        // Saturate down: 11 -> 10 -> 01 -> 00 -> 00.
        for (int i = 0; i < 5; i++) cycle("sat_down", 32'h40, 1, 1, 0, 0, 0, 0, 0);

        // Stall: branch held in ID three cycles, one increment on release.
        cycle("stall_fetch", 32'h44, 1, 0, 0, 0, 0, 0, 0);
        cycle("stall_fetch2", 32'h44, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("stall_hold", 32'h48, 1, 0, 1, 1, 0, 1, 0);
        cycle("stall_release", 32'h0, 0, 0, 1, 1, 0, 0, 0);
        cycle("stall_after", 32'h44, 1, 0, 0, 0, 0, 0, 0);

        // Flush a predicted-taken branch; resolution next cycle must be ignored.
        cycle("flush_fetch", 32'h44, 1, 0, 1, 1, 0, 0, 1);
        cycle("flush_ignore", 32'h44, 1, 1, 0, 0, 0, 0, 0);
        cycle("flush_after", 32'h44, 1, 0, 0, 0, 0, 0, 0);

        // Aliasing: 0x40 and 0x80 share idx 0; miss pattern 1, 0, 1.
        cycle("alias_a", 32'h40, 1, 0, 0, 0, 0, 0, 0);
        cycle("alias_b", 32'h80, 1, 1, 0, 1, 1, 0, 0);
        cycle("alias_c", 32'h40, 1, 0, 1, 0, 0, 0, 0);
        cycle("alias_d", 32'h80, 1, 1, 0, 1, 1, 0, 0);
        cycle("alias_e", 32'h0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic over a handful of aliasing PCs.
        for (int n = 0; n < 400; n++) begin
            pick = int'($urandom_range(0, 5));
            rpc  = {$urandom_range(0, 3), 2'b00} << 2;
            rpc  = rpc | (32'(pick) << 2) | (32'($urandom_range(0, 1)) << 8);
            rbr  = ($urandom_range(0, 3) != 0);
            rbeq = m_valid ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 7) == 0);
            rbne = m_valid ? (!rbeq && $urandom_range(0, 9) < 8) : 1'b0;
            cycle("rand", rpc, rbr, rbeq, rbne, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);

            // Occasional asynchronous reset mid-cycle.
            rst_bit = ($urandom_range(0, 199) == 0) || (n == 250);
            if (rst_bit) begin
                #1;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("midreset.BrPre", bus.BrPre_o, 1'b0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Prediction unit that supplies the prediction bit consumed by the ID-stage branch comparator, and is trained by that comparator's resolution outputs.
- Holds a PC-indexed table of 2-bit saturating counters.
- Gives a combinational taken/not-taken prediction in IF.
- Carries that prediction through its own IF/ID-aligned register, so the comparator sees the prediction for the branch currently in ID.
- Updates the table when the branch leaves ID.

Parameters:
IDX_W, 4, table index width; 2^IDX_W entries, index = pc[IDX_W+1:2].
INIT_STATE, 2'b01, counter reset value; 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall_i  input  1  IF/ID hold; the ID-aligned registers keep their value.
flush_i  input  1  IF/ID clear; ID-aligned registers are zeroed on the next unstalled edge.
if_pc_i  input  32  PC of the instruction in IF.
if_is_branch_i  input  1  IF pre-decode: the instruction is beq/bne.
BrPre_if_o  output  1  IF prediction for the PC mux, combinational.
BrPre_o  output  1  registered prediction for the branch in ID, to the comparator.
Brncheq_i  input  1  ID instruction is beq.
Brnchne_i  input  1  ID instruction is bne.
Branch_i  input  1  resolved outcome from the comparator; 1 = taken.
missPre_i  input  1  comparator mispredict flag; used only for statistics.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - All counters = INIT_STATE.
  - id_pred = 0, id_idx = 0, id_valid = 0.
  - Therefore BrPre_o = 0.
  - Statistics counters = 0 (when the optional feature is compiled in).
  - Reset mid-operation discards any pending update.
- IF lookup (combinational, 0 latency):
  - if_idx = if_pc_i[IDX_W+1:2].
  - BrPre_if_o = if_is_branch_i & ctr[if_idx][1].
- ID-aligned register, updated each rising edge:
  - stall_i = 1: hold. Stall has priority over flush.
  - else if flush_i = 1: id_pred = 0, id_valid = 0, id_idx = 0.
  - else: id_pred = BrPre_if_o, id_valid = if_is_branch_i, id_idx = if_idx.
  - BrPre_o = id_pred, so there is 1 cycle of latency from IF to ID.
- Training:
  - upd = id_valid & (Brncheq_i | Brnchne_i) & ~stall_i.
  - An update fires exactly once per branch, on the edge where the branch leaves ID. Updates during stall cycles are suppressed because operands may still be unforwarded.
  - Branch_i = 1: ctr[id_idx] increments, saturating at 11.
  - Branch_i = 0: ctr[id_idx] decrements, saturating at 00.
  - If id_valid = 1 but neither Brncheq_i nor Brnchne_i is set (pre-decode alias), there is no update.
- Simultaneous read and write of the same index:
  - IF lookup returns the pre-update value; there is no bypass.
  - The new value is visible from the next cycle.
- Aliasing: PCs sharing index bits share a counter. This is accepted; there are no tags.
- Counter FSM per entry: SN(00) <-> WN(01) <-> WT(10) <-> ST(11).
  - Taken moves right; not-taken moves left.
  - Endpoints self-loop.

Optional Feature:
Macro BRPRED_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - On each upd: miss_cnt increments if missPre_i = 1, else hit_cnt increments.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined:
  - The ports and logic are absent.
  - Prediction behaviour is identical in both builds.

Decomposition:
- Shared package:
  - Counter-state localparams SN/WN/WT/ST.
  - Function sat_update(state, taken) returning the next 2-bit state.
  - Default IDX_W.
- One natural sub-module, brpred_counter: a single 2-bit saturating counter with enable, taken, and async reset to INIT_STATE. It is instantiated 2^IDX_W times via generate.
- The ID register and index decode stay in the top module.

Test Plan:
- Reset: rst_n = 0 for 2 cycles, then release. Required: BrPre_o = 0; with if_is_branch_i = 1 at any PC, BrPre_if_o = 0 (INIT_STATE 01).
- Training to taken: beq at pc 0x40 (idx 0), resolved Branch_i = 1 three times. Required: ctr[0] goes 01 -> 10 -> 11 -> 11; BrPre_if_o = 1 from the first lookup after the first update.
- Saturation down: from 11, four not-taken resolutions. Required: 11 -> 10 -> 01 -> 00 -> 00; BrPre_if_o = 0 after the second.
- Stall hold: branch in ID with stall_i = 1 for 3 cycles, Branch_i = 1. Required: BrPre_o is held, ctr is unchanged during the stall, and exactly one increment occurs on release.
- Flush: flush_i = 1 with if_is_branch_i = 1 (predicted taken). Required: next-cycle BrPre_o = 0, id_valid = 0, no update even if Brncheq_i = 1.
- Aliasing and statistics (BRPRED_STATS_EN defined): pc 0x40 and pc 0x80 (IDX_W = 4, both idx 0), alternating outcomes with missPre_i patterns 1, 0, 1. Required: a shared counter, miss_cnt_o = 2, hit_cnt_o = 1.
